// File: rtl/passcode_lock_ctrl_if.sv
// Keypad-side bundle for passcode_lock_ctrl: strobes in from the keypad, lock status out.
// Handshake: digit_valid, enter, clear and lock are single-cycle strobes with no ready/back-pressure; the controller samples every asserted strobe on the rising clk edge.
interface passcode_lock_ctrl_if #(
  parameter int DIGIT_W  = 4,
  parameter int CODE_LEN = 8
);
  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);

  logic               digit_valid;
  logic [DIGIT_W-1:0] digit;
  logic               enter;
  logic               clear;
  logic               lock;
  logic               new_code;
  logic               unlocked;
  logic               perm_locked;
  logic               err;
  logic [CODE_W-1:0]  entry_buf;
  logic [CNT_W-1:0]   entry_cnt;
  logic [3:0]         fail_cnt;
  logic [2:0]         state_out;

  modport master (
    output digit_valid, digit, enter, clear, lock, new_code,
    input  unlocked, perm_locked, err, entry_buf, entry_cnt, fail_cnt, state_out
  );

  modport slave (
    input  digit_valid, digit, enter, clear, lock, new_code,
    output unlocked, perm_locked, err, entry_buf, entry_cnt, fail_cnt, state_out
  );
endinterface

// File: rtl/passcode_lock_ctrl.sv
// Passcode lock: digit entry buffer, code check with failure counting and permanent lockout,
// optional idle auto-relock and a two-entry code change sequence.
module passcode_lock_ctrl #(
  parameter int                           DIGIT_W      = 4,
  parameter int                           CODE_LEN     = 8,
  parameter int                           MAX_FAILS    = 3,
  parameter int                           RELOCK_CYC   = 0,
  parameter logic [DIGIT_W*CODE_LEN-1:0]  DEFAULT_CODE = 32'h12345678
) (
  input logic                clk,
  input logic                reset,
  passcode_lock_ctrl_if.slave bus
);
  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int CNT_W  = $clog2(CODE_LEN + 1);
  localparam int IDLE_W = (RELOCK_CYC > 1) ? $clog2(RELOCK_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(CODE_LEN);
  localparam logic [3:0]        MAX_F     = 4'(MAX_FAILS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((RELOCK_CYC > 0) ? RELOCK_CYC - 1 : 0);

  typedef enum logic [2:0] {
    ST_ENTRY    = 3'd0,
    ST_CHECK    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_NEW1     = 3'd3,
    ST_NEW2     = 3'd4,
    ST_PERMLOCK = 3'd5
  } state_t;

  state_t             state;
  logic [CODE_W-1:0]  entry_buf;
  logic [CNT_W-1:0]   entry_cnt;
  logic [CODE_W-1:0]  stored_code;
  logic [CODE_W-1:0]  candidate;
  logic [3:0]         fail_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               err;
  logic               full;

  assign full = (entry_cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_ENTRY;
      entry_buf   <= '0;
      entry_cnt   <= '0;
      stored_code <= DEFAULT_CODE;
      candidate   <= '0;
      fail_cnt    <= '0;
      idle_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (state != ST_UNLOCKED) idle_cnt <= '0;
      case (state)
        ST_ENTRY: begin
          // lock here aborts a partial entry
          if (bus.lock || bus.clear) begin
            entry_buf <= '0;
            entry_cnt <= '0;
          end else if (bus.enter) begin
            if (full) begin
              state <= ST_CHECK;
            end else begin
              err       <= 1'b1;
              entry_buf <= '0;
              entry_cnt <= '0;
            end
          end else if (bus.digit_valid && !full) begin
            entry_buf <= {entry_buf[CODE_W-DIGIT_W-1:0], bus.digit};
            entry_cnt <= entry_cnt + 1'b1;
          end
        end
        ST_CHECK: begin
          // buffer is wiped either way so the accepted code is not left on entry_buf
          entry_buf <= '0;
          entry_cnt <= '0;
          if (entry_buf == stored_code) begin
            fail_cnt <= '0;
            state    <= ST_UNLOCKED;
          end else begin
            err <= 1'b1;
            if (fail_cnt >= MAX_F - 4'd1) begin
              fail_cnt <= MAX_F;
              state    <= ST_PERMLOCK;
            end else begin
              fail_cnt <= fail_cnt + 4'd1;
              state    <= ST_ENTRY;
            end
          end
        end
        ST_UNLOCKED: begin
          if (bus.lock) begin
            entry_buf <= '0;
            entry_cnt <= '0;
            state     <= ST_ENTRY;
          end else if (bus.new_code) begin
            entry_buf <= '0;
            entry_cnt <= '0;
            state     <= ST_NEW1;
          end else if (bus.clear || bus.enter || bus.digit_valid) begin
            idle_cnt <= '0;
            if (bus.clear) begin
              entry_buf <= '0;
              entry_cnt <= '0;
            end
          end else if (RELOCK_CYC != 0 && idle_cnt == IDLE_LAST) begin
            entry_buf <= '0;
            entry_cnt <= '0;
            state     <= ST_ENTRY;
          end else if (RELOCK_CYC != 0) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_NEW1, ST_NEW2: begin
          if (bus.lock) begin
            entry_buf <= '0;
            entry_cnt <= '0;
            state     <= ST_ENTRY;
          end else if (bus.clear) begin
            entry_buf <= '0;
            entry_cnt <= '0;
          end else if (bus.enter) begin
            entry_buf <= '0;
            entry_cnt <= '0;
            if (state == ST_NEW1) begin
              if (full) begin
                candidate <= entry_buf;
                state     <= ST_NEW2;
              end else begin
                err <= 1'b1;
              end
            end else begin
              // a failed confirmation keeps the old code but still returns to UNLOCKED
              if (full && entry_buf == candidate) stored_code <= entry_buf;
              else err <= 1'b1;
              state <= ST_UNLOCKED;
            end
          end else if (bus.digit_valid && !full) begin
            entry_buf <= {entry_buf[CODE_W-DIGIT_W-1:0], bus.digit};
            entry_cnt <= entry_cnt + 1'b1;
          end
        end
        ST_PERMLOCK: begin
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

  assign bus.unlocked    = (state == ST_UNLOCKED) || (state == ST_NEW1) || (state == ST_NEW2);
  assign bus.perm_locked = (state == ST_PERMLOCK);
  assign bus.err         = err;
  assign bus.entry_buf   = entry_buf;
  assign bus.entry_cnt   = entry_cnt;
  assign bus.fail_cnt    = fail_cnt;
  assign bus.state_out   = state;
endmodule

// File: tb/tb_passcode_lock_ctrl.sv
// Directed bench for passcode_lock_ctrl: a vector table against a RELOCK_CYC=0 instance,
// plus hand-written auto-relock sequences against a RELOCK_CYC=10 instance.
module tb_passcode_lock_ctrl;
  localparam logic [2:0] S_ENTRY = 3'd0, S_CHECK = 3'd1, S_UNL = 3'd2;
  localparam logic [2:0] S_NEW1 = 3'd3, S_NEW2 = 3'd4, S_PERM = 3'd5;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  passcode_lock_ctrl_if #(.DIGIT_W(4), .CODE_LEN(8)) bus_m ();
  passcode_lock_ctrl_if #(.DIGIT_W(4), .CODE_LEN(8)) bus_r ();

  passcode_lock_ctrl #(.MAX_FAILS(3), .RELOCK_CYC(0)) dut_m (
    .clk(clk), .reset(reset), .bus(bus_m)
  );
  passcode_lock_ctrl #(.MAX_FAILS(3), .RELOCK_CYC(10)) dut_r (
    .clk(clk), .reset(reset), .bus(bus_r)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r, dv;
    logic [3:0]  dg;
    logic        en, cl, lk, nc;
    logic [2:0]  st;
    logic [3:0]  cnt, fl;
    logic        er;
    logic [31:0] bf;
    logic        cb;
  } vec_t;

  vec_t vq[$];

  // driver: inputs change 1 ns after the edge and are checked 1 ns after the next one
  task automatic drive(input logic r, dv, input logic [3:0] dg, input logic en, cl, lk, nc);
    reset = r;
    bus_m.digit_valid = dv; bus_m.digit = dg; bus_m.enter = en;
    bus_m.clear = cl; bus_m.lock = lk; bus_m.new_code = nc;
    bus_r.digit_valid = dv; bus_r.digit = dg; bus_r.enter = en;
    bus_r.clear = cl; bus_r.lock = lk; bus_r.new_code = nc;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus_m.digit_valid = 1'b0; bus_m.enter = 1'b0; bus_m.clear = 1'b0;
    bus_m.lock = 1'b0; bus_m.new_code = 1'b0;
    bus_r.digit_valid = 1'b0; bus_r.enter = 1'b0; bus_r.clear = 1'b0;
    bus_r.lock = 1'b0; bus_r.new_code = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic r, dv, input logic [3:0] dg, input logic en, cl, lk, nc,
                              input logic [2:0] st, input logic [3:0] cnt, fl, input logic er,
                              input logic [31:0] bf, input logic cb);
    vec_t v;
    v.r = r; v.dv = dv; v.dg = dg; v.en = en; v.cl = cl; v.lk = lk; v.nc = nc;
    v.st = st; v.cnt = cnt; v.fl = fl; v.er = er; v.bf = bf; v.cb = cb;
    vq.push_back(v);
  endfunction

  // first n digits of code, most significant nibble first
  function automatic void digits(input logic [31:0] code, input int n, input logic [2:0] st,
                                 input logic [3:0] fl);
    for (int i = 0; i < n; i++)
      add(0, 1, code[31-4*i -: 4], 0, 0, 0, 0, st, 4'(i + 1), fl, 0, code >> (4 * (7 - i)), 1);
  endfunction

  function automatic void unlock_seq(input logic [31:0] code, input logic [3:0] fl);
    digits(code, 8, S_ENTRY, fl);
    add(0, 0, 0, 1, 0, 0, 0, S_CHECK, 8, fl, 0, code, 1);
    add(0, 0, 0, 0, 0, 0, 0, S_UNL, 0, 0, 0, 0, 0);
  endfunction

  function automatic void fail_seq(input logic [31:0] code, input logic [3:0] fl,
                                   input logic [2:0] next_st);
    digits(code, 8, S_ENTRY, fl);
    add(0, 0, 0, 1, 0, 0, 0, S_CHECK, 8, fl, 0, code, 1);
    add(0, 0, 0, 0, 0, 0, 0, next_st, 0, fl + 4'd1, 1, 0, 1);
  endfunction

  function automatic void build_table();
    // correct default code, then relock
    unlock_seq(32'h12345678, 0);
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    // short entry rejected without counting a failure
    digits(32'h12345678, 5, S_ENTRY, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_ENTRY, 0, 0, 1, 0, 1);
    // ninth digit dropped, then clear, then digit+clear together
    digits(32'h12345678, 8, S_ENTRY, 0);
    add(0, 1, 4'h9, 0, 0, 0, 0, S_ENTRY, 8, 0, 0, 32'h12345678, 1);
    add(0, 0, 0, 0, 1, 0, 0, S_ENTRY, 0, 0, 0, 0, 1);
    add(0, 1, 4'h5, 0, 1, 0, 0, S_ENTRY, 0, 0, 0, 0, 1);
    // clear beats enter; enter beats digit
    digits(32'h12345678, 8, S_ENTRY, 0);
    add(0, 0, 0, 1, 1, 0, 0, S_ENTRY, 0, 0, 0, 0, 1);
    digits(32'h12345678, 8, S_ENTRY, 0);
    add(0, 1, 4'hA, 1, 0, 0, 0, S_CHECK, 8, 0, 0, 32'h12345678, 1);
    add(0, 0, 0, 0, 0, 0, 0, S_UNL, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    // three wrong codes -> permanent lock, which ignores everything
    fail_seq(32'h11111111, 0, S_ENTRY);
    fail_seq(32'h11111111, 1, S_ENTRY);
    fail_seq(32'h11111111, 2, S_PERM);
    for (int i = 0; i < 8; i++)
      add(0, 1, 4'(i + 1), 0, 0, 0, 0, S_PERM, 0, 3, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, S_PERM, 0, 3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, S_PERM, 0, 3, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, S_ENTRY, 0, 0, 0, 0, 1);
    // code change to 87654321, old code then rejected
    unlock_seq(32'h12345678, 0);
    add(0, 0, 0, 0, 0, 0, 1, S_NEW1, 0, 0, 0, 0, 1);
    digits(32'h87654321, 8, S_NEW1, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_NEW2, 0, 0, 0, 0, 1);
    digits(32'h87654321, 8, S_NEW2, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_UNL, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    fail_seq(32'h12345678, 0, S_ENTRY);
    unlock_seq(32'h87654321, 1);
    // reset mid-entry restores the default code
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    digits(32'h87654321, 3, S_ENTRY, 0);
    add(1, 0, 0, 0, 0, 0, 0, S_ENTRY, 0, 0, 0, 0, 1);
    unlock_seq(32'h12345678, 0);
    // mismatched confirmation keeps the old code
    add(0, 0, 0, 0, 0, 0, 1, S_NEW1, 0, 0, 0, 0, 1);
    digits(32'h11112222, 8, S_NEW1, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_NEW2, 0, 0, 0, 0, 1);
    digits(32'h11113333, 8, S_NEW2, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_UNL, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    unlock_seq(32'h12345678, 0);
    // short entry in NEW1, then abort with lock
    add(0, 0, 0, 0, 0, 0, 1, S_NEW1, 0, 0, 0, 0, 1);
    digits(32'h55555555, 3, S_NEW1, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_NEW1, 0, 0, 1, 0, 1);
    digits(32'h55555555, 2, S_NEW1, 0);
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    unlock_seq(32'h12345678, 0);
    // abort from NEW2 leaves the code unchanged
    add(0, 0, 0, 0, 0, 0, 1, S_NEW1, 0, 0, 0, 0, 1);
    digits(32'h24682468, 8, S_NEW1, 0);
    add(0, 0, 0, 1, 0, 0, 0, S_NEW2, 0, 0, 0, 0, 1);
    digits(32'h24682468, 8, S_NEW2, 0);
    add(0, 0, 0, 0, 0, 1, 0, S_ENTRY, 0, 0, 0, 0, 1);
    unlock_seq(32'h12345678, 0);
  endfunction

  task automatic relock_unlock();
    logic [31:0] code;
    code = 32'h12345678;
    for (int i = 0; i < 8; i++) drive(0, 1, code[31-4*i -: 4], 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("relock_unlocked", {29'd0, bus_r.state_out}, {29'd0, S_UNL});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    bus_m.digit_valid = 0; bus_m.digit = 0; bus_m.enter = 0; bus_m.clear = 0;
    bus_m.lock = 0; bus_m.new_code = 0;
    bus_r.digit_valid = 0; bus_r.digit = 0; bus_r.enter = 0; bus_r.clear = 0;
    bus_r.lock = 0; bus_r.new_code = 0;
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("rst_state", {29'd0, bus_m.state_out}, 32'd0);
    chk("rst_unlocked", {31'd0, bus_m.unlocked}, 32'd0);
    chk("rst_perm", {31'd0, bus_m.perm_locked}, 32'd0);
    chk("rst_buf", bus_m.entry_buf, 32'd0);
    chk("rst_cnt", {28'd0, bus_m.entry_cnt}, 32'd0);
    chk("rst_fail", {28'd0, bus_m.fail_cnt}, 32'd0);
    chk("rst_err", {31'd0, bus_m.err}, 32'd0);

    build_table();
    foreach (vq[k]) begin
      drive(vq[k].r, vq[k].dv, vq[k].dg, vq[k].en, vq[k].cl, vq[k].lk, vq[k].nc);
      chk($sformatf("v%0d_state", k), {29'd0, bus_m.state_out}, {29'd0, vq[k].st});
      chk($sformatf("v%0d_unlocked", k), {31'd0, bus_m.unlocked},
          {31'd0, (vq[k].st == S_UNL || vq[k].st == S_NEW1 || vq[k].st == S_NEW2)});
      chk($sformatf("v%0d_perm", k), {31'd0, bus_m.perm_locked}, {31'd0, (vq[k].st == S_PERM)});
      chk($sformatf("v%0d_fail", k), {28'd0, bus_m.fail_cnt}, {28'd0, vq[k].fl});
      chk($sformatf("v%0d_err", k), {31'd0, bus_m.err}, {31'd0, vq[k].er});
      if (vq[k].cb) begin
        chk($sformatf("v%0d_cnt", k), {28'd0, bus_m.entry_cnt}, {28'd0, vq[k].cnt});
        chk($sformatf("v%0d_buf", k), bus_m.entry_buf, vq[k].bf);
      end
    end

    // auto-relock exactly 10 idle cycles after entering UNLOCKED
    drive(1, 0, 0, 0, 0, 0, 0);
    relock_unlock();
    for (int c = 1; c <= 10; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("relock_idle_c%0d", c), {29'd0, bus_r.state_out},
          {29'd0, (c == 10) ? S_ENTRY : S_UNL});
    end
    // activity at cycle 5 restarts the count
    relock_unlock();
    for (int c = 1; c <= 4; c++) drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("relock_after_clear", {29'd0, bus_r.state_out}, {29'd0, S_UNL});
    for (int c = 1; c <= 10; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("relock_restart_c%0d", c), {29'd0, bus_r.state_out},
          {29'd0, (c == 10) ? S_ENTRY : S_UNL});
    end
    chk("no_relock_when_disabled", {29'd0, bus_m.state_out}, {29'd0, S_UNL});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
